// File: rtl/pyramic_clk_pkg.sv
// Shared constants and helpers for the multi-channel NCO clock generator.
package pyramic_clk_pkg;

    localparam int unsigned AccWDefault = 32;

    // 12.288 MHz codec clock from a 100 MHz system clock: 2^32 * 12.288 / 100
    localparam logic [31:0] ResetIncDefault = 32'h1F75_104D;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One fractional phase accumulator. Reprogramming is deferred to a carry so the
// output never shows a runt or stretched period.
module nco_channel #(
    parameter int unsigned     AccW     = 32,
    parameter logic [AccW-1:0] ResetInc = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic            run_fall_i,
    input  logic            en_i,
    input  logic            cfg_we_i,
    input  logic [AccW-1:0] cfg_inc_i,
    input  logic [AccW-1:0] cfg_phase_i,
    output logic            pend_o,
    output logic            tick_o,
    output logic            clk_out_o,
    output logic            settled_o
);

    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] inc_q, inc_d;
    logic [AccW-1:0] inc_pend_q, inc_pend_d;
    logic [AccW-1:0] phase_pend_q, phase_pend_d;
    logic [AccW-1:0] start_q, start_d;
    logic            pend_q, pend_d;
    logic            preload_q, preload_d;
    logic            settled_q, settled_d;
    logic            tick_q, tick_d;
    logic            clk_out_q, clk_out_d;
    logic            en_prev_q;

    logic            active;
    logic            carry;
    logic [AccW-1:0] base;
    logic [AccW:0]   sum;

    assign active = run_i & en_i;
    // A phase programmed while idle seeds the first active cycle instead of acc.
    assign base   = preload_q ? start_q : acc_q;
    assign sum    = {1'b0, base} + {1'b0, inc_q};
    assign carry  = sum[AccW];

    always_comb begin
        acc_d        = acc_q;
        inc_d        = inc_q;
        inc_pend_d   = inc_pend_q;
        phase_pend_d = phase_pend_q;
        start_d      = start_q;
        pend_d       = pend_q;
        preload_d    = preload_q;
        settled_d    = settled_q;
        tick_d       = 1'b0;
        clk_out_d    = 1'b0;

        if (active) begin
            acc_d     = sum[AccW-1:0];
            preload_d = 1'b0;
            if (carry && pend_q) begin
                acc_d  = sum[AccW-1:0] + phase_pend_q;
                inc_d  = inc_pend_q;
                pend_d = 1'b0;
            end
            tick_d    = carry;
            clk_out_d = acc_d[AccW-1];
        end else begin
            acc_d = '0;
            if (pend_q) begin
                inc_d     = inc_pend_q;
                start_d   = phase_pend_q;
                preload_d = 1'b1;
                pend_d    = 1'b0;
            end
        end

        // Only accepted while nothing is pending, so it never collides with an apply.
        if (cfg_we_i) begin
            inc_pend_d   = cfg_inc_i;
            phase_pend_d = cfg_phase_i;
            pend_d       = 1'b1;
        end

        if (cfg_we_i || run_fall_i || (en_i != en_prev_q)) begin
            settled_d = 1'b0;
        end else if (active && carry) begin
            settled_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            inc_q        <= ResetInc;
            inc_pend_q   <= '0;
            phase_pend_q <= '0;
            start_q      <= '0;
            pend_q       <= 1'b0;
            preload_q    <= 1'b0;
            settled_q    <= 1'b0;
            tick_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            en_prev_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            inc_pend_q   <= inc_pend_d;
            phase_pend_q <= phase_pend_d;
            start_q      <= start_d;
            pend_q       <= pend_d;
            preload_q    <= preload_d;
            settled_q    <= settled_d;
            tick_q       <= tick_d;
            clk_out_q    <= clk_out_d;
            en_prev_q    <= en_i;
        end
    end

    assign pend_o    = pend_q;
    assign tick_o    = tick_q;
    assign clk_out_o = clk_out_q;
    assign settled_o = settled_q;

endmodule

// File: rtl/pyramic_nco_clk_gen.sv
// Multi-channel NCO clock/strobe generator: config decode, ready mux and lock
// reduction around NUM_CH independent accumulators.
module pyramic_nco_clk_gen
    import pyramic_clk_pkg::*;
#(
    parameter int unsigned      NUM_CH    = 4,
    parameter int unsigned      ACC_W     = AccWDefault,
    parameter int unsigned      CH_IDX_W  = 4,
    parameter logic [ACC_W-1:0] RESET_INC = ACC_W'(ResetIncDefault)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   clk_out,
    output logic                locked
);

    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] settled;
    logic [NUM_CH-1:0] cfg_we;
    logic              run_q;
    logic              run_fall;
    logic              locked_q, locked_d;

    assign run_fall = run_q & ~run;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_sel[i] = (32'(cfg_ch) == 32'(i));

        nco_channel #(
            .AccW     (ACC_W),
            .ResetInc (RESET_INC)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset_n),
            .run_i       (run),
            .run_fall_i  (run_fall),
            .en_i        (ch_en[i]),
            .cfg_we_i    (cfg_we[i]),
            .cfg_inc_i   (cfg_inc),
            .cfg_phase_i (cfg_phase),
            .pend_o      (pend[i]),
            .tick_o      (tick[i]),
            .clk_out_o   (clk_out[i]),
            .settled_o   (settled[i])
        );
    end

    // Out-of-range channel selects nothing, so it is always ready and dropped.
    assign cfg_ready = ~|(ch_sel & pend);
    assign cfg_we    = {NUM_CH{cfg_valid}} & ch_sel & ~pend;

    assign locked_d = run & (|ch_en) & (&(settled | ~ch_en));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            run_q    <= run;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_pyramic_nco_clk_gen.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// hand-computed directed expectations for the key scenarios.
module tb_pyramic_nco_clk_gen;

    localparam int N = 3;
    localparam logic [31:0] RstInc = 32'h1F75_104D;
    localparam longint unsigned Mod = 64'h1_0000_0000;

    logic        clk, reset_n, run, cfg_valid;
    logic [N-1:0] ch_en;
    logic [3:0]  cfg_ch;
    logic [31:0] cfg_inc, cfg_phase;
    logic        cfg_ready, locked;
    logic [N-1:0] tick, clk_out;

    int checks = 0;
    int errors = 0;

    pyramic_nco_clk_gen #(
        .NUM_CH    (N),
        .ACC_W     (32),
        .CH_IDX_W  (4),
        .RESET_INC (RstInc)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .tick      (tick),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint unsigned m_acc[N], m_inc[N], m_ipend[N], m_ppend[N], m_start[N];
    bit              m_pend[N], m_pre[N], m_set[N], m_enprev[N];
    logic [N-1:0]    m_tick, m_clk;
    logic            m_locked;
    bit              m_runprev;

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_inc[i] = RstInc; m_ipend[i] = 0; m_ppend[i] = 0;
            m_start[i] = 0; m_pend[i] = 0; m_pre[i] = 0; m_set[i] = 0; m_enprev[i] = 0;
        end
        m_tick = '0; m_clk = '0; m_locked = 1'b0; m_runprev = 1'b0;
    endtask

    task automatic mdl_step();
        bit all_set = 1'b1;
        bit nlock;
        for (int i = 0; i < N; i++) if (ch_en[i] && !m_set[i]) all_set = 1'b0;
        nlock = run && (ch_en != 0) && all_set;
        for (int i = 0; i < N; i++) begin
            bit act, carry, hit;
            longint unsigned s;
            act   = run && ch_en[i];
            hit   = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
            carry = 1'b0;
            if (act) begin
                s = (m_pre[i] ? m_start[i] : m_acc[i]) + m_inc[i];
                carry = (s >= Mod);
                m_acc[i] = s % Mod;
                m_pre[i] = 1'b0;
                if (carry && m_pend[i]) begin
                    m_acc[i] = (m_acc[i] + m_ppend[i]) % Mod;
                    m_inc[i] = m_ipend[i];
                    m_pend[i] = 1'b0;
                end
                m_tick[i] = carry;
                m_clk[i]  = (m_acc[i] >= Mod / 2);
            end else begin
                m_acc[i] = 0; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
                if (m_pend[i]) begin
                    m_inc[i] = m_ipend[i]; m_start[i] = m_ppend[i];
                    m_pre[i] = 1'b1; m_pend[i] = 1'b0;
                end
            end
            if (hit) begin
                m_ipend[i] = cfg_inc; m_ppend[i] = cfg_phase; m_pend[i] = 1'b1;
            end
            if (hit || (m_runprev && !run) || (ch_en[i] != m_enprev[i])) m_set[i] = 1'b0;
            else if (act && carry) m_set[i] = 1'b1;
            m_enprev[i] = ch_en[i];
        end
        m_locked  = nlock;
        m_runprev = run;
    endtask

    initial begin
        mdl_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) mdl_reset();
            else mdl_step();
        end
    end

    function automatic logic exp_ready();
        int idx = int'(cfg_ch);
        if (idx >= N) return 1'b1;
        return !m_pend[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_tick", 32'(tick), 32'(m_tick));
        check("model_clk_out", 32'(clk_out), 32'(m_clk));
        check("model_locked", 32'(locked), 32'(m_locked));
        check("model_cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int last, k, min_iv, first_iv, last_iv, cnt, bad;
        bit stall, lock_low, dropped, drop_next;

        reset_n = 1'b1; run = 1'b0; ch_en = '0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
        #1 reset_n = 1'b0;
        #10;
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        #11 reset_n = 1'b1;

        // Basic period: program ch0 while idle, then run
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_inc = 32'h4000_0000; cfg_phase = 32'h0;
        step(1);
        cfg_valid = 1'b0;
        step(2);
        run = 1'b1; ch_en = 3'b001;
        for (int j = 1; j <= 12; j++) begin
            next_neg();
            check("basic_tick0", 32'(tick[0]), 32'((j % 4) == 0));
            check("basic_clk0", 32'(clk_out[0]), 32'(((j % 4) == 2) || ((j % 4) == 3)));
            check("basic_locked", 32'(locked), 32'(j >= 5));
            check("basic_tick_hi", 32'(tick[2:1]), 32'h0);
        end

        // Mid-run reconfiguration to half period, with a second stalled request
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_inc = 32'h8000_0000; cfg_phase = 32'h0;
        @(negedge clk);
        check("reconf_ready_idle", 32'(cfg_ready), 32'h1);
        last = 12; min_iv = 1000; first_iv = 0; last_iv = 0;
        stall = 0; lock_low = 0; dropped = 0; drop_next = 0;
        for (k = 14; k <= 43; k++) begin
            @(posedge clk);
            if (drop_next) begin
                #2 cfg_valid = 1'b0;
                dropped = 1; drop_next = 0;
            end
            @(negedge clk);
            if (!cfg_ready) stall = 1;
            if (stall && cfg_ready && !dropped && !drop_next) drop_next = 1;
            if (!locked) lock_low = 1;
            if (tick[0]) begin
                if (first_iv == 0) first_iv = k - last;
                last_iv = k - last;
                if (k - last < min_iv) min_iv = k - last;
                last = k;
            end
        end
        check("reconf_stall_seen", 32'(stall), 32'h1);
        check("reconf_second_accepted", 32'(dropped), 32'h1);
        check("reconf_lock_dropped", 32'(lock_low), 32'h1);
        check("reconf_relocked", 32'(locked), 32'h1);
        check("reconf_first_interval", 32'(first_iv), 32'd4);
        check("reconf_min_interval", 32'(min_iv), 32'd2);
        check("reconf_last_interval", 32'(last_iv), 32'd2);

        // Inactive preload on ch1: first active edge carries
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_inc = 32'h4000_0000; cfg_phase = 32'hC000_0000;
        step(1);
        cfg_valid = 1'b0;
        step(1);
        ch_en = 3'b011;
        for (int j = 1; j <= 9; j++) begin
            next_neg();
            check("preload_tick1", 32'(tick[1]), 32'((j % 4) == 1));
            check("preload_clk1", 32'(clk_out[1]), 32'(((j % 4) == 3) || ((j % 4) == 0)));
        end

        // Out-of-range channel is accepted and dropped
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd3; cfg_inc = 32'h0; cfg_phase = 32'h0;
        @(negedge clk);
        check("oor_cfg_ready", 32'(cfg_ready), 32'h1);
        step(1);
        cfg_valid = 1'b0; cfg_ch = 4'd0;

        // Zero increment on ch2 keeps lock low
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_inc = 32'h0; cfg_phase = 32'h0;
        step(1);
        cfg_valid = 1'b0; cfg_ch = 4'd0;
        step(1);
        ch_en = 3'b111;
        for (int j = 1; j <= 20; j++) begin
            next_neg();
            check("inc0_locked", 32'(locked), 32'h0);
            check("inc0_tick2", 32'(tick[2]), 32'h0);
        end

        // run deassert clears all outputs on the next edge
        step(1);
        run = 1'b0;
        next_neg();
        check("stop_tick", 32'(tick), 32'h0);
        check("stop_clk_out", 32'(clk_out), 32'h0);
        check("stop_locked", 32'(locked), 32'h0);

        // Async reset mid-run, then fractional rate from the reset increment
        step(1);
        run = 1'b1;
        step(10);
        reset_n = 1'b0;
        #1;
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_clk_out", 32'(clk_out), 32'h0);
        check("arst_locked", 32'(locked), 32'h0);
        step(1);
        reset_n = 1'b1; ch_en = 3'b001;
        cnt = 0; last = -1; bad = 0;
        for (int j = 1; j <= 25000; j++) begin
            next_neg();
            if (tick[0]) begin
                cnt++;
                if (last >= 0 && (j - last) != 8 && (j - last) != 9) bad++;
                last = j;
            end
        end
        check("frac_bad_intervals", 32'(bad), 32'h0);
        checks++;
        if (cnt < 3071 || cnt > 3073) begin
            errors++;
            $display("FAIL frac_tick_count: got %0d expected 3071..3073", cnt);
        end

        step(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
